core_issue_window: RTL

Parametrised in-order issue window for the TOY core. It generalises the single-instruction decode cascade into a registered buffer of `DEPTH` fetched instructions with a register scoreboard, and issues up to `ISSUE_W` instructions per cycle. It supports one non-blocking outstanding memory operation, stalls on control transfers, and halts. It sits between fetch and the ALU/LSU/jump datapath.

---
 rtl/core_issue_window.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_issue_window.sv
// core_issue_window
//
// In-order issue window for the TOY core. Buffers up to DEPTH fetched
// instructions in an age-ordered FIFO (slot 0 oldest), tracks the single
// outstanding load destination in a one-entry scoreboard, and issues up to
// ISSUE_W instructions per cycle from the head of the window.
//
// Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   fetch_valid_i       fetch offers fetch_instr_i / fetch_pc_i
//   fetch_ready_o       a slot is free (registered state only)
//   issue_valid_o       per-lane issue strobes, contiguous from lane 0
//   issue_instr_o       lane k word in bits [16k+15:16k]
//   issue_pc_o          lane k pc in bits [8k+7:8k]
//   ctrl_done_i         issued control op resolved
//   ctrl_taken_i        resolved control op redirected (flushes the window)
//   lsu_done_i          outstanding memory op completed
//   mem_busy_o          a memory op is outstanding
//   halted_o            a halt has issued; terminal until reset
module core_issue_window #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ISSUE_W = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fetch_valid_i,
   input  logic [15:0]            fetch_instr_i,
   input  logic [7:0]             fetch_pc_i,
   output logic                   fetch_ready_o,
   output logic [ISSUE_W-1:0]     issue_valid_o,
   output logic [16*ISSUE_W-1:0]  issue_instr_o,
   output logic [8*ISSUE_W-1:0]   issue_pc_o,
   input  logic                   ctrl_done_i,
   input  logic                   ctrl_taken_i,
   input  logic                   lsu_done_i,
   output logic                   mem_busy_o,
   output logic                   halted_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      StRun,
      StWaitCtrl,
      StHalted
   } state_e;

   // ------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------
   function automatic logic reads_rs(input logic [3:0] op);
      return op inside {[4'h1:4'h6]};
   endfunction

   function automatic logic reads_rt(input logic [3:0] op);
      return op inside {[4'h1:4'h6], 4'ha, 4'hb};
   endfunction

   function automatic logic reads_rd(input logic [3:0] op);
      return op inside {4'h9, 4'hb, 4'hc, 4'hd, 4'he};
   endfunction

   function automatic logic writes_rd(input logic [3:0] op);
      return op inside {[4'h1:4'h8], 4'ha, 4'hf};
   endfunction

   function automatic logic is_mem(input logic [3:0] op);
      return op inside {[4'h8:4'hb]};
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return op inside {4'h8, 4'ha};
   endfunction

   function automatic logic is_ctrl(input logic [3:0] op);
      return op inside {[4'hc:4'hf]};
   endfunction

   function automatic logic is_halt(input logic [3:0] op);
      return op == 4'h0;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e        state_q;
   logic [CW-1:0] count_q;
   logic          mem_busy_q;
   logic [3:0]    pend_rd_q;
   logic [15:0]   slot_instr_q [DEPTH];
   logic [7:0]    slot_pc_q    [DEPTH];
   logic [15:0]   slot_instr_d [DEPTH];
   logic [7:0]    slot_pc_d    [DEPTH];
   logic [CW-1:0] count_d;

   // Issue scan results
   logic [ISSUE_W-1:0] issue_valid;
   logic [CW-1:0]      issue_cnt;
   logic               issue_mem;
   logic               issue_load;
   logic [3:0]         issue_ld_rd;
   logic               lead_ctrl;
   logic               lead_halt;

   // Scan scratch
   logic        scan_go;
   logic        blk;
   logic        pend_valid;
   logic        mem_taken;
   logic [15:0] lane_dirty;
   logic [3:0]  op;
   logic [3:0]  rd;
   logic [3:0]  rs;
   logic [3:0]  rt;

   logic          accept;
   logic          flush;
   logic          wr_en;
   logic [CW-1:0] wr_pos;

   assign fetch_ready_o = (count_q < DEPTH_C) && (state_q != StHalted);
   assign mem_busy_o    = mem_busy_q;
   assign halted_o      = (state_q == StHalted);
   assign issue_valid_o = issue_valid;

   // pend_rd of zero means no register is waiting (R0 is never dirty, stores leave it zero)
   assign pend_valid = mem_busy_q && (pend_rd_q != 4'd0);

   // ------------------------------------------------------------------
   // Issue scan: lane k examines slot k, stopping at the first empty or
   // blocked slot. lane_dirty collects destinations issued earlier this cycle.
   // ------------------------------------------------------------------
   always_comb begin
      issue_valid = '0;
      issue_cnt   = '0;
      issue_mem   = 1'b0;
      issue_load  = 1'b0;
      issue_ld_rd = 4'd0;
      lead_ctrl   = 1'b0;
      lead_halt   = 1'b0;
      scan_go     = (state_q == StRun);
      mem_taken   = 1'b0;
      lane_dirty  = 16'd0;
      blk         = 1'b0;
      op          = 4'd0;
      rd          = 4'd0;
      rs          = 4'd0;
      rt          = 4'd0;
      for (int k = 0; k < int'(ISSUE_W); k++) begin
         op  = slot_instr_q[k][15:12];
         rd  = slot_instr_q[k][11:8];
         rs  = slot_instr_q[k][7:4];
         rt  = slot_instr_q[k][3:0];
         blk = 1'b0;
         if (CW'(k) >= count_q) blk = 1'b1;
         // RAW and WAW against the outstanding load
         if (pend_valid && ((reads_rs(op) && rs == pend_rd_q) ||
                            (reads_rt(op) && rt == pend_rd_q) ||
                            ((reads_rd(op) || writes_rd(op)) && rd == pend_rd_q))) begin
            blk = 1'b1;
         end
         // RAW against an older lane in this same cycle
         if ((reads_rs(op) && lane_dirty[rs]) || (reads_rt(op) && lane_dirty[rt]) ||
             (reads_rd(op) && lane_dirty[rd])) begin
            blk = 1'b1;
         end
         if (is_mem(op) && (mem_busy_q || mem_taken)) blk = 1'b1;
         if ((is_ctrl(op) || is_halt(op)) && k != 0) blk = 1'b1;
         if (is_halt(op) && mem_busy_q) blk = 1'b1;

         if (scan_go && !blk) begin
            issue_valid[k] = 1'b1;
            issue_cnt      = issue_cnt + 1'b1;
            if (writes_rd(op) && rd != 4'd0) lane_dirty[rd] = 1'b1;
            if (is_mem(op)) begin
               mem_taken   = 1'b1;
               issue_mem   = 1'b1;
               issue_load  = is_load(op);
               issue_ld_rd = rd;
            end
            // Control transfers and halts only reach here from lane 0 and issue alone
            if (is_ctrl(op)) begin
               lead_ctrl = 1'b1;
               scan_go   = 1'b0;
            end
            if (is_halt(op)) begin
               lead_halt = 1'b1;
               scan_go   = 1'b0;
            end
         end else begin
            scan_go = 1'b0;
         end
      end
   end

   always_comb begin
      issue_instr_o = '0;
      issue_pc_o    = '0;
      for (int k = 0; k < int'(ISSUE_W); k++) begin
         issue_instr_o[16*k +: 16] = slot_instr_q[k];
         issue_pc_o[8*k +: 8]      = slot_pc_q[k];
      end
   end

   // ------------------------------------------------------------------
   // Compaction: survivors shift down by issue_cnt, a fetched word lands
   // just above them. A taken redirect empties the window and drops the fetch.
   // ------------------------------------------------------------------
   assign accept = fetch_valid_i && fetch_ready_o;
   assign flush  = (state_q == StWaitCtrl) && ctrl_done_i && ctrl_taken_i;
   assign wr_en  = accept && !flush;
   assign wr_pos = count_q - issue_cnt;

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         slot_instr_d[i] = slot_instr_q[i];
         slot_pc_d[i]    = slot_pc_q[i];
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (j == i + int'(issue_cnt)) begin
               slot_instr_d[i] = slot_instr_q[j];
               slot_pc_d[i]    = slot_pc_q[j];
            end
         end
         if (wr_en && CW'(i) == wr_pos) begin
            slot_instr_d[i] = fetch_instr_i;
            slot_pc_d[i]    = fetch_pc_i;
         end
      end
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q - issue_cnt + {{(CW-1){1'b0}}, wr_en};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_instr_q[i] <= 16'd0;
            slot_pc_q[i]    <= 8'd0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_instr_q[i] <= slot_instr_d[i];
            slot_pc_q[i]    <= slot_pc_d[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Window FSM and memory scoreboard
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StRun;
         mem_busy_q <= 1'b0;
         pend_rd_q  <= 4'd0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (lead_halt) begin
                  state_q <= StHalted;
               end else if (lead_ctrl) begin
                  state_q <= StWaitCtrl;
               end
            end
            StWaitCtrl: begin
               if (ctrl_done_i) state_q <= StRun;
            end
            StHalted: begin
               state_q <= StHalted;
            end
            default: begin
               state_q <= StRun;
            end
         endcase

         // A memory op can only issue while idle, so it never races lsu_done_i
         if (issue_mem) begin
            mem_busy_q <= 1'b1;
            pend_rd_q  <= issue_load ? issue_ld_rd : 4'd0;
         end else if (lsu_done_i) begin
            mem_busy_q <= 1'b0;
            pend_rd_q  <= 4'd0;
         end
      end
   end

endmodule
